perf_event_counter_bank: RTL
============================

Name: perf_event_counter_bank

Overview:
- Parametrised successor to the core's hard-wired miss/rw statistics counters.
- Counts NUM_CH independent event lines coming from the pipeline, caches and hazard logic; each channel is programmable as edge or level counting.
- Adds sticky overflow flags, atomic snapshot and global enable/clear.
- Read/write access is a simple debug register port, in the same style as the CPU_Debug cache ports; sits beside the RV32I core top.

Parameters:
- NUM_CH, 4, number of event channels (1..16)
- CNT_W, 32, counter width in bits (8..32)
- AW, 6, register address width; must satisfy 2^AW >= 4 + 2*NUM_CH

Ports:
- CPU_CLK  input  1  clock, all state on rising edge
- CPU_RST  input  1  reset, asynchronous, active-high
- event_in  input  NUM_CH  raw event lines, one per channel, synchronous to CPU_CLK
- dbg_we  input  1  register write strobe
- dbg_addr  input  AW  register address, shared by read and write
- dbg_wdata  input  32  write data
- dbg_rdata  output  32  registered read data
- ovf_any  output  1  OR of all overflow flags

Behaviour:
- Register map (word index):
  - 0 CTRL: bit0 EN (R/W). bit1 SNAP (write-1 pulse, reads 0). bit2 CLR (write-1 pulse, reads 0).
  - 1 MODE: bit i = 1 means channel i counts rising edges; 0 means it counts high cycles. R/W.
  - 2 OVF: bit i is a sticky overflow flag; write-1-to-clear.
  - 3 reserved: reads 0.
  - 4+i: live counter i; a write loads dbg_wdata[CNT_W-1:0].
  - 4+NUM_CH+i: snapshot i; read-only.
  - Unmapped addresses read 0; writes to them are ignored.
- Reset values: all counters 0; snapshots 0; MODE 0; OVF 0; prev-event register 0; EN = 1, so the block counts out of reset; dbg_rdata 0; ovf_any 0.
- Edge detect: prev_i <= event_in[i] every cycle, regardless of EN. Edge hit = event_in[i] & ~prev_i.
- Increment condition: inc_i = EN & (MODE[i] ? edge hit : event_in[i]). At most +1 per channel per cycle.
- Wrap: a counter at 2^CNT_W-1 that receives inc goes to 0 and sets OVF[i] in the same edge.
- Read latency: dbg_rdata updates 1 cycle after dbg_addr is presented. Counters are zero-extended to 32 bits. The read returns the value held before that cycle's update.
- Priority per channel counter, highest first:
  1. CLR → 0
  2. direct write → wdata
  3. inc → +1
- Snapshot on SNAP: snap_i <= counter_i value before this cycle's update, so the set is atomic across channels. SNAP and CLR in the same write: the snapshot takes the pre-clear values and the counters go to 0.
- Counter write or CLR in the same cycle as a wrap-increment: OVF is not set, because the increment is discarded.
- CLR does not clear OVF, MODE, EN or the snapshots.
- OVF write-1-to-clear coinciding with a new overflow on the same bit: the set wins, and the bit stays 1.
- Clearing EN freezes the counters; edge tracking continues, so no false edge is seen on re-enable.
- Changing MODE takes effect on the next cycle's counting.
- ovf_any is combinational OR of the OVF register.
- CPU_RST asserted mid-operation: immediate asynchronous return to the reset values; a pending SNAP or CLR is lost.

Test Plan:
- Reset, then hold event_in[0]=1 for 5 cycles with MODE=0 → counter0 reads 5. With MODE[0]=1 → counter0 reads 1.
- Toggle event_in[1] with period 2 for 10 cycles in edge mode, then clear EN and toggle 4 more times, then set EN → counter1 = 5 and stays 5 during the disabled period; the first post-enable edge gives 6.
- Write counter2 = 0xFFFFFFFE (CNT_W=32) and pulse event_in[2] twice in edge mode → counter2 = 0, OVF=0b0100, ovf_any=1. Write OVF=0b0100 → OVF=0; a W1C in the same cycle as a wrap leaves OVF[2]=1.
- Counters at {7,3,9,1}: write CTRL=0b111 while event_in=4'hF in level mode → snapshots read {7,3,9,1} and counters read 0 the next cycle. A subsequent CLR-only write leaves the snapshots unchanged.
- Counter write and increment in the same cycle on channel 3 → counter3 = written value, no +1.
- Read address 3 and address 4+2*NUM_CH → 0. Assert CPU_RST mid-count → every register reads its reset value on the next read, and EN=1.

Source files
------------

// File: rtl/perf_event_counter_bank.sv
// rtl/perf_event_counter_bank.sv - programmable per-channel event counters with overflow flags and snapshot
module perf_event_counter_bank #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 32,
    parameter int AW     = 6
) (
    input  logic              CPU_CLK,
    input  logic              CPU_RST,
    input  logic [NUM_CH-1:0] event_in,
    input  logic              dbg_we,
    input  logic [AW-1:0]     dbg_addr,
    input  logic [31:0]       dbg_wdata,
    output logic [31:0]       dbg_rdata,
    output logic              ovf_any
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic              en;
    logic [NUM_CH-1:0] mode;
    logic [NUM_CH-1:0] ovf;
    logic [NUM_CH-1:0] prev;
    logic [CNT_W-1:0]  cnt  [NUM_CH];
    logic [CNT_W-1:0]  snap [NUM_CH];

    logic              wr_ctrl;
    logic              wr_mode;
    logic              wr_ovf;
    logic              snap_pulse;
    logic              clr_pulse;
    logic [NUM_CH-1:0] inc;
    logic [NUM_CH-1:0] cnt_wr;
    logic [NUM_CH-1:0] wrap;
    logic [NUM_CH-1:0] ovf_next;
    logic [31:0]       rd_next;

    assign wr_ctrl    = dbg_we && (dbg_addr == AW'(0));
    assign wr_mode    = dbg_we && (dbg_addr == AW'(1));
    assign wr_ovf     = dbg_we && (dbg_addr == AW'(2));
    assign snap_pulse = wr_ctrl && dbg_wdata[1];
    assign clr_pulse  = wr_ctrl && dbg_wdata[2];

    // A wrap only flags overflow when the increment actually lands.
    always_comb begin
        inc    = '0;
        cnt_wr = '0;
        wrap   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            inc[i]    = en && (mode[i] ? (event_in[i] && !prev[i]) : event_in[i]);
            cnt_wr[i] = dbg_we && (dbg_addr == AW'(4 + i));
            wrap[i]   = inc[i] && (cnt[i] == CNT_MAX) && !clr_pulse && !cnt_wr[i];
        end
    end

    // New overflow beats a simultaneous write-1-to-clear.
    assign ovf_next = (ovf & ~(wr_ovf ? dbg_wdata[NUM_CH-1:0] : '0)) | wrap;
    assign ovf_any  = |ovf;

    always_comb begin
        rd_next = '0;
        if (dbg_addr == AW'(0)) begin
            rd_next[0] = en;
        end else if (dbg_addr == AW'(1)) begin
            rd_next[NUM_CH-1:0] = mode;
        end else if (dbg_addr == AW'(2)) begin
            rd_next[NUM_CH-1:0] = ovf;
        end
        for (int i = 0; i < NUM_CH; i++) begin
            if (dbg_addr == AW'(4 + i)) begin
                rd_next = 32'(cnt[i]);
            end
            if (dbg_addr == AW'(4 + NUM_CH + i)) begin
                rd_next = 32'(snap[i]);
            end
        end
    end

    always_ff @(posedge CPU_CLK or posedge CPU_RST) begin
        if (CPU_RST) begin
            en        <= 1'b1;
            mode      <= '0;
            ovf       <= '0;
            prev      <= '0;
            dbg_rdata <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                cnt[i]  <= '0;
                snap[i] <= '0;
            end
        end else begin
            prev      <= event_in;
            ovf       <= ovf_next;
            dbg_rdata <= rd_next;
            if (wr_ctrl) begin
                en <= dbg_wdata[0];
            end
            if (wr_mode) begin
                mode <= dbg_wdata[NUM_CH-1:0];
            end
            for (int i = 0; i < NUM_CH; i++) begin
                if (snap_pulse) begin
                    snap[i] <= cnt[i];
                end
                if (clr_pulse) begin
                    cnt[i] <= '0;
                end else if (cnt_wr[i]) begin
                    cnt[i] <= dbg_wdata[CNT_W-1:0];
                end else if (inc[i]) begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

endmodule
